// File: rtl/weight_bank_pkg.sv
// Shared types and helpers for the loadable multi-channel weight memory.
package weight_bank_pkg;

    // Load phase fills the banks; ready phase serves read requests.
    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        READY = 1'b1
    } wb_state_e;

    // Channel counter needs at least one bit, even for a single channel.
    function automatic int ch_cnt_width(input int num_channels);
        int w;
        if (num_channels > 1) begin
            w = $clog2(num_channels);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// One single-port weight bank with a registered read port.
// The read register only updates when read enable is high, so a stalled
// consumer keeps seeing the same word. This is the technology-specific
// piece: swap the behavioural array for an SRAM macro of matching shape.
module weight_bank_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_SIZE  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_SIZE-1:0]  wdata_i,
    output logic [WORD_SIZE-1:0]  rdata_o
);

    logic [WORD_SIZE-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
    logic [WORD_SIZE-1:0] rdata_r;

    // Storage array write; contents are not reset, as in a real SRAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[addr_i] <= wdata_i;
        end
    end

    // Registered read, held while read enable is low.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_r <= {WORD_SIZE{1'b0}};
        end else if (re_i) begin
            rdata_r <= mem_r[addr_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/weight_bank_mem.sv
// Loadable multi-channel weight memory: streamed fill after reset, then
// NUM_CHANNELS words per address through a valid/ready request port and a
// valid/yumi response port with one-cycle latency.
module weight_bank_mem
    import weight_bank_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DEPTH        = 2**ADDR_WIDTH,
    parameter int WORD_SIZE    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int LAYER_NUMBER = 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [WORD_SIZE-1:0]              load_data_i,
    input  logic                              load_valid_i,
    output logic                              load_ready_o,
    output logic                              loaded_o,
    input  logic                              reload_i,
    input  logic [ADDR_WIDTH-1:0]             rd_addr_i,
    input  logic                              rd_valid_i,
    output logic                              rd_ready_o,
    output logic [NUM_CHANNELS*WORD_SIZE-1:0] data_o,
    output logic                              valid_o,
    input  logic                              yumi_i
);

    localparam int                    CW        = ch_cnt_width(NUM_CHANNELS);
    localparam logic [CW-1:0]         CH_LAST   = CW'(NUM_CHANNELS - 1);
    localparam logic [CW-1:0]         CH_ONE    = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

    wb_state_e                 state_r;
    wb_state_e                 state_nxt_s;
    logic [CW-1:0]             ch_cnt_r;
    logic [ADDR_WIDTH-1:0]     addr_cnt_r;
    logic                      valid_r;
    logic                      oor_r;
    logic                      oor_s;
    logic                      load_ready_s;
    logic                      loaded_s;
    logic                      load_fire_s;
    logic                      last_word_s;
    logic                      rd_ready_s;
    logic                      rd_fire_s;
    logic [ADDR_WIDTH-1:0]     bank_addr_s;
    logic [NUM_CHANNELS-1:0]   bank_we_s;
    logic [WORD_SIZE-1:0]      bank_rdata_s [NUM_CHANNELS];

    // A word arriving together with reload is dropped: reload restarts the
    // fill at word 0 and that word would otherwise land at the old position.
    assign load_fire_s = load_valid_i & load_ready_s & ~reload_i;
    assign last_word_s = load_fire_s & (ch_cnt_r == CH_LAST) & (addr_cnt_r == ADDR_LAST);
    assign rd_ready_s  = (state_r == READY) & ~reload_i & (~valid_r | yumi_i);
    assign rd_fire_s   = rd_valid_i & rd_ready_s;
    assign oor_s       = ({1'b0, rd_addr_i} >= DEPTH_L);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: finish loading on the last word, reload returns to LOAD.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (last_word_s) begin
                    state_nxt_s = READY;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            READY: begin
                if (reload_i) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = READY;
                end
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        load_ready_s = 1'b0;
        loaded_s     = 1'b0;
        case (state_r)
            LOAD:    load_ready_s = 1'b1;
            READY:   loaded_s     = 1'b1;
            default: begin
                load_ready_s = 1'b0;
                loaded_s     = 1'b0;
            end
        endcase
    end

    // Fill position: channel counter wraps and carries into the address counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ch_cnt_r   <= {CW{1'b0}};
            addr_cnt_r <= {ADDR_WIDTH{1'b0}};
        end else if (reload_i) begin
            ch_cnt_r   <= {CW{1'b0}};
            addr_cnt_r <= {ADDR_WIDTH{1'b0}};
        end else if (load_fire_s) begin
            if (ch_cnt_r == CH_LAST) begin
                ch_cnt_r   <= {CW{1'b0}};
                addr_cnt_r <= addr_cnt_r + ADDR_ONE;
            end else begin
                ch_cnt_r   <= ch_cnt_r + CH_ONE;
            end
        end
    end

    // Response valid and out-of-range flag for the word currently in the banks.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_r <= 1'b0;
            oor_r   <= 1'b0;
        end else if ((state_r == READY) && reload_i) begin
            valid_r <= 1'b0;
        end else if (rd_fire_s) begin
            valid_r <= 1'b1;
            oor_r   <= oor_s;
        end else if (yumi_i) begin
            valid_r <= 1'b0;
        end
    end

    // Single-port banks: the fill counter drives the address while loading.
    always_comb begin
        if (state_r == LOAD) begin
            bank_addr_s = addr_cnt_r;
        end else begin
            bank_addr_s = rd_addr_i;
        end
    end

    // Per-bank write enable selected by the channel counter.
    always_comb begin
        bank_we_s = {NUM_CHANNELS{1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            bank_we_s[c] = load_fire_s & (ch_cnt_r == CW'(c));
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_bank
        weight_bank_ram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .WORD_SIZE  (WORD_SIZE)
        ) u_bank (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .we_i    (bank_we_s[g]),
            .re_i    (rd_fire_s),
            .addr_i  (bank_addr_s),
            .wdata_i (load_data_i),
            .rdata_o (bank_rdata_s[g])
        );
    end

    // Response data straight from the bank read registers, zeroed when out of range.
    always_comb begin
        data_o = {(NUM_CHANNELS*WORD_SIZE){1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (oor_r) begin
                data_o[c*WORD_SIZE +: WORD_SIZE] = {WORD_SIZE{1'b0}};
            end else begin
                data_o[c*WORD_SIZE +: WORD_SIZE] = bank_rdata_s[c];
            end
        end
    end

    assign load_ready_o = load_ready_s;
    assign loaded_o     = loaded_s;
    assign rd_ready_o   = rd_ready_s;
    assign valid_o      = valid_r;

endmodule

// File: doc/weight_bank_mem.md
# weight_bank_mem

Parametrised, multi-channel, loadable weight memory. It replaces the single-port fixed-content ROM used by the conv, hidden and output layers. After reset the block is filled through a streaming load port, because ASIC SRAMs carry no init file. It then serves reads of NUM_CHANNELS words per address through a valid/ready request port and a valid/yumi response port, with one-cycle memory latency and no data loss under back-pressure.

## Interface
Parameters:
- ADDR_WIDTH, 6, address bits per bank.
- DEPTH, 2**ADDR_WIDTH, words per bank actually used; 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- WORD_SIZE, 16, bits per word.
- NUM_CHANNELS, 4, number of parallel banks, ≥ 1.
- LAYER_NUMBER, 1, layer tag; informational only, no functional effect.

Ports:
- clk_i  in  1  single clock; everything is sampled on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- load_data_i  in  WORD_SIZE  weight word.
- load_valid_i  in  1  load word present.
- load_ready_o  out  1  block accepts a load word.
- loaded_o  out  1  all DEPTH*NUM_CHANNELS words are written.
- reload_i  in  1  discard the current contents and restart loading.
- rd_addr_i  in  ADDR_WIDTH  read address.
- rd_valid_i  in  1  read request.
- rd_ready_o  out  1  read request accepted.
- data_o  out  NUM_CHANNELS*WORD_SIZE  channel c occupies bits [c*WORD_SIZE +: WORD_SIZE].
- valid_o  out  1  data_o holds a read result.
- yumi_i  in  1  consumer takes data_o this cycle; legal only while valid_o is high.

## Operation
- FSM states:
  - LOAD: load_ready_o=1.
  - READY: loaded_o=1.
- Reset enters LOAD with word count k=0.
- In LOAD, a word is accepted on any cycle with load_valid_i & load_ready_o.
- Accepted word k is written to bank (k mod NUM_CHANNELS) at address (k div NUM_CHANNELS).
- Implement the channel and address counters separately; the channel counter wraps and carries into the address counter.
- When the word with k = DEPTH*NUM_CHANNELS−1 is accepted, the FSM goes LOAD→READY on the next edge.
- In LOAD: rd_ready_o=0 and valid_o=0.
- In READY: load_ready_o=0 and load words are ignored.
- rd_ready_o = (state==READY) & !reload_i & (!valid_o | yumi_i).
- An accepted read asserts read-enable on every bank at rd_addr_i.
- Banks are read only on an accepted request, so bank outputs stay stable while the response is stalled. data_o is taken directly from the bank outputs; there is no extra output register.
- If rd_addr_i ≥ DEPTH, the read is still accepted and data_o returns all zeros.
- reload_i in READY:
  - next state is LOAD, counters reset to 0, loaded_o drops, valid_o clears;
  - any unconsumed response is discarded;
  - bank contents remain until they are overwritten.
- reload_i in LOAD restarts the counters at 0.
- Arithmetic: both counters are unsigned. The address counter is ADDR_WIDTH bits; the channel counter is $clog2(NUM_CHANNELS) bits, minimum 1.

## Timing
- Reset values: load_ready_o=1, loaded_o=0, rd_ready_o=0, valid_o=0, data_o=0.
- Load throughput: one word per cycle. load_ready_o falls in the cycle after the final word is accepted.
- Read latency: a request accepted at edge t gives valid_o=1 with data_o valid after edge t+1, i.e. in the cycle after acceptance.
- Throughput: with yumi_i held high, one read per cycle.
- valid_o rules:
  - set by acceptance;
  - cleared by yumi_i without a simultaneous new acceptance;
  - stays 1 if yumi_i and a new acceptance occur in the same cycle.
- With valid_o=1 and yumi_i=0, data_o and valid_o hold indefinitely.
- reload_i and rd_valid_i in the same cycle: reload wins and the request is not accepted.
- reset_i has priority over everything, including mid-load and stalled-response cases.

## Structure
- Package weight_bank_pkg holds:
  - the state enum typedef (LOAD, READY);
  - a function computing the channel-counter width.
- Sub-module weight_bank_ram is one WORD_SIZE×2**ADDR_WIDTH single-port bank with:
  - write enable and read enable;
  - 1-cycle registered read;
  - output held when read enable is low.
- weight_bank_ram is generated NUM_CHANNELS times. It is the only technology-specific piece: a behavioural array, or an SRAM macro chosen by width and depth.

## Test plan
- Load. DEPTH=8, NUM_CHANNELS=4, stream words k+1 for k=0..31 with one idle cycle every third word. Required: loaded_o rises after the 32nd accepted word, and load_ready_o=0 afterwards.
- Basic read. After the load above, read addr 3 with yumi_i=1. Required: the next cycle has valid_o=1 and data_o channels 0..3 = 13, 14, 15, 16.
- Back-to-back reads. Request addrs 0..7 on consecutive cycles with yumi_i=1 throughout. Required: eight consecutive valid cycles, channel 0 = 1, 5, 9, …, 29.
- Stall. Accept a read of addr 2 and hold yumi_i=0 for 3 cycles. Required: data_o stays {12,11,10,9} (channel 3…0), rd_ready_o=0 throughout, and one response only.
- Out-of-range read. Read addr 8 (DEPTH=8, ADDR_WIDTH=4). Required: valid_o=1 with data_o=0.
- Reload and reset. Raise reload_i together with rd_valid_i during a stalled response. Required: no acceptance, valid_o=0, LOAD is entered, and reloading words 100..131 then gives addr 0 = {103,102,101,100}. Separately, assert reset_i after 5 load words. Required: counters return to 0.
